// File: rtl/ifd2_cap.sv
// ifd2_cap: two-pin input capture with resynchronisation, optional glitch
// filter and a timestamped change-event FIFO (first-word-fall-through).
// Build option: define IFD2_FILTER_EN to build the FILT_LEN-sample glitch
// filter; without it the synchronised level is taken on every edge.
module ifd2_cap #(
   parameter int FILT_LEN = 4,
   parameter int TS_W     = 16,
   parameter int DEPTH    = 4
) (
   input  logic              CK,
   input  logic              RST_N,
   input  logic              I0,
   input  logic              I1,
   output logic              Q0,
   output logic              Q1,
   output logic              EV_VALID,
   input  logic              EV_READY,
   output logic [TS_W+3:0]   EV_DATA,
   output logic              OVF,
   input  logic              OVF_CLR
);

   localparam int EW = TS_W + 4;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_F = (AW+1)'(DEPTH);

   // Elaboration-time parameter range guards
   if (FILT_LEN < 2 || FILT_LEN > 255) begin : g_bad_filt_len
      $error("ifd2_cap: FILT_LEN out of range 2..255");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ifd2_cap: DEPTH must be a power of two >= 2");
   end

   logic [1:0]      ir_q, ir_d;
   logic [1:0]      sy_q, sy_d;
   logic [1:0]      stable_q, stable_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            push_q, push_d;
   logic [EW-1:0]   word_q, word_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   mem_d [DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW:0]     fill_q, fill_d;
   logic [EW-1:0]   data_q, data_d;
   logic            ovf_q, ovf_d;

   logic [1:0]      chg_s;
   logic            pop_s;
   logic            full_s;
   logic            wr_en_s;
   logic            drop_s;

   // Two-flop capture chain: input register then resync flop
   always_comb begin
      ir_d = {I1, I0};
      sy_d = ir_q;
   end

`ifdef IFD2_FILTER_EN
   localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);
   logic [7:0] fcnt_q [2];
   logic [7:0] fcnt_d [2];

   // Glitch filter: accept a new level only after FILT_LEN differing samples
   always_comb begin
      stable_d = stable_q;
      fcnt_d   = fcnt_q;
      for (int p = 0; p < 2; p++) begin
         if (sy_q[p] == stable_q[p]) begin
            fcnt_d[p] = 8'd0;
         end else if (fcnt_q[p] == FILT_LAST) begin
            stable_d[p] = sy_q[p];
            fcnt_d[p]   = 8'd0;
         end else begin
            fcnt_d[p] = fcnt_q[p] + 8'd1;
         end
      end
   end

   // Filter counter registers
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         fcnt_q[0] <= 8'd0;
         fcnt_q[1] <= 8'd0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end
`else
   // Unfiltered: the synchronised level is the stable level
   always_comb begin
      stable_d = sy_q;
   end
`endif

   // Event formation: stamp with the count before this edge's increment
   always_comb begin
      chg_s  = stable_d ^ stable_q;
      push_d = |chg_s;
      word_d = {chg_s[1], chg_s[0], stable_d[1], stable_d[0], ts_q};
      ts_d   = ts_q + TS_W'(1);
   end

   // FIFO bookkeeping, drop/overflow and the held head-of-queue output
   always_comb begin
      pop_s   = (fill_q != '0) && EV_READY;
      full_s  = (fill_q == DEPTH_F);
      wr_en_s = push_q && (!full_s || pop_s);
      drop_s  = push_q && full_s && !pop_s;
      mem_d   = mem_q;
      if (wr_en_s) begin
         mem_d[wr_q] = word_q;
      end else begin
         mem_d[wr_q] = mem_q[wr_q];
      end
      wr_d = wr_en_s ? wr_q + AW'(1) : wr_q;
      rd_d = pop_s ? rd_q + AW'(1) : rd_q;
      case ({wr_en_s, pop_s})
         2'b10:   fill_d = fill_q + (AW+1)'(1);
         2'b01:   fill_d = fill_q - (AW+1)'(1);
         default: fill_d = fill_q;
      endcase
      if (fill_d != '0) begin
         data_d = mem_d[rd_d];
      end else begin
         data_d = data_q;
      end
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (OVF_CLR) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         ir_q     <= 2'b00;
         sy_q     <= 2'b00;
         stable_q <= 2'b00;
         ts_q     <= '0;
         push_q   <= 1'b0;
         word_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         fill_q   <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         sy_q     <= sy_d;
         stable_q <= stable_d;
         ts_q     <= ts_d;
         push_q   <= push_d;
         word_q   <= word_d;
         mem_q    <= mem_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      Q0       = stable_q[0];
      Q1       = stable_q[1];
      EV_VALID = (fill_q != '0);
      EV_DATA  = data_q;
      OVF      = ovf_q;
   end

endmodule

// File: doc/ifd2_cap.md
# ifd2_cap

Two-pin input capture block: the receive-side counterpart to the team's two-bit registered output stage. It registers two external pins I0/I1 in input flops, resynchronises them to CK, optionally glitch-filters them, and presents clean levels on Q0/Q1. Every change in filtered level is queued as a timestamped event in a small FIFO, drained over a valid/ready handshake by the LCAR control logic.

## Interface
- FILT_LEN, 4: consecutive differing samples needed to accept a level change; range 2..255.
- TS_W, 16: timestamp counter width.
- DEPTH, 4: event FIFO depth; power of two, at least 2.

- CK  in  1  clock; all flops rise-edge.
- RST_N  in  1  asynchronous, active-low reset.
- I0, I1  in  1  external pins, asynchronous to CK.
- Q0, Q1  out  1  filtered levels.
- EV_VALID  out  1  FIFO not empty.
- EV_READY  in  1  consumer accepts head entry.
- EV_DATA  out  TS_W+4  head entry: [TS_W+3]=chg1, [TS_W+2]=chg0, [TS_W+1]=Q1 new, [TS_W]=Q0 new, [TS_W-1:0]=timestamp.
- OVF  out  1  sticky overflow flag.
- OVF_CLR  in  1  clears OVF.

## Operation
- Per pin, the input register (ir) feeds a sync flop (sy). This gives 2 flops before any logic uses the value.
- Filter, per pin, with an 8-bit counter cnt:
  - sy == stable: cnt <= 0.
  - sy != stable and cnt == FILT_LEN-1: stable <= sy, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - A single matching sample aborts a pending change.
- Q0/Q1 are driven directly by stable0/stable1.
- Timestamp ts: free-running TS_W-bit counter that wraps from all-ones to 0.
- Event generation: on any edge where stable0 or stable1 changes, one entry is pushed.
  - chgN = 1 for each pin that changed.
  - Level fields hold the new values.
  - ts field holds the counter value before that edge's increment.
  - Both pins changing on the same edge produce one entry with chg1 = chg0 = 1.
- FIFO: first-word-fall-through with DEPTH entries.
  - EV_DATA shows the head entry whenever EV_VALID = 1. It is held at the last value when empty.
  - Pop occurs when EV_VALID && EV_READY.
  - Push while full and no pop: entry dropped, OVF <= 1.
  - Push while full with a pop on the same edge: push accepted, occupancy unchanged.
  - Push into an empty FIFO: visible on EV_VALID on the following cycle.
- OVF is set by a drop and cleared by OVF_CLR. If both happen on the same edge, set wins.

## Timing
- Reset (RST_N low, asynchronous): ir, sy, stable, cnt, ts, FIFO pointers, EV_DATA and OVF all 0. Q0 = Q1 = 0, EV_VALID = 0.
- Pins high at reset release: the block reports a rising event after the normal latency.
- Latency with filter: pin change sampled by ir at edge k gives sy at k+1. Q changes at edge k+FILT_LEN+1. EV_VALID rises at k+FILT_LEN+2.
- Latency without filter: Q changes at k+2. EV_VALID rises at k+3.
- Throughput: one pop per cycle. The consumer may hold EV_READY high continuously.
- Reset asserted mid-operation discards queued events and any partially filtered change.

## Configuration
- IFD2_FILTER_EN defined: the glitch filter is built as specified above.
- IFD2_FILTER_EN undefined:
  - FILT_LEN is ignored and no counters are built.
  - stable <= sy on every edge.
  - Events are still generated on every stable change.

## Test plan
- Reset, FILTER_EN, FILT_LEN=4: hold I0=1 from cycle 0. Q0 rises 5 edges after the ir sample; one entry with chg0=1, Q0 new=1, ts=5 appears.
- Glitch rejection, FILTER_EN, FILT_LEN=4: I1 pulse 3 cycles wide gives no Q1 change and no event. A 4-cycle pulse gives a rise event, then a fall event.
- Simultaneous change: I0 and I1 toggle together gives one entry with chg1=chg0=1 and both level fields updated.
- Overflow, DEPTH=4, EV_READY=0: six level changes give 4 entries and OVF=1. A pop concurrent with the 5th push keeps 4 entries. OVF_CLR plus a drop on the same edge leaves OVF=1.
- Wrap, TS_W=4: an event at ts=15 is followed by the next event stamped 0..14 correctly.
- Without the macro: I0 edge gives Q0 at k+2, and a 1-cycle glitch produces two events.
